// File: rtl/risc_io_pkg.sv
// Shared types and line levels for the RISC output UART logger.
package risc_io_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_t;

  localparam int UART_DATA_BITS = 8;

  localparam logic LINE_IDLE  = 1'b1;
  localparam logic LINE_START = 1'b0;
  localparam logic LINE_STOP  = 1'b1;

  function automatic logic even_parity(input logic [UART_DATA_BITS-1:0] b);
    return ^b;
  endfunction

endpackage

// File: rtl/out_log_fifo.sv
// Synchronous FIFO for captured words; extra pointer MSB separates full from empty.
module out_log_fifo #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic [DATA_W-1:0] wdata,
  input  logic              pop,
  output logic [DATA_W-1:0] rdata,
  output logic              full,
  output logic              empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]       wr_ptr;
  logic [AW:0]       rd_ptr;
  logic [DATA_W-1:0] mem [DEPTH];
  logic              wr_en;
  logic              rd_en;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign rd_en = pop & ~empty;
  // A pop on the same edge frees the slot, so a push while full is still accepted.
  assign wr_en = push & (~full | rd_en);
  assign rdata = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (rd_en) rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  // NOTE: storage is not reset; the pointers alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/risc_out_uart_logger.sv
// Captures changes of the RISC outrisc port and sends each word as two UART bytes, low first.
// Define OUT_LOG_PARITY_EN for an even-parity bit (8E1); default build is 8N1.
module risc_out_uart_logger
  import risc_io_pkg::*;
#(
  parameter int DATA_W       = 16,
  parameter int FIFO_DEPTH   = 8,
  parameter int CLKS_PER_BIT = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] outrisc_in,
  output logic              uart_tx,
  output logic              busy,
  output logic              fifo_full,
  output logic              overflow
);

  localparam int                CNT_W    = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [2:0]        BIT_LAST = 3'(UART_DATA_BITS - 1);

  logic [DATA_W-1:0]         prev_q;
  logic [DATA_W-1:0]         rdata;
  logic                      change;
  logic                      pop;
  logic                      empty;
  logic                      bit_end;
  tx_state_t                 state;
  logic [CNT_W-1:0]          bit_cnt;
  logic [2:0]                bit_idx;
  logic                      byte_sel;
  logic [UART_DATA_BITS-1:0] shift_q;
  logic [UART_DATA_BITS-1:0] hi_q;
`ifdef OUT_LOG_PARITY_EN
  logic                      parity_q;
`endif

  assign change  = (outrisc_in != prev_q);
  assign pop     = (state == IDLE) & ~empty;
  assign bit_end = (bit_cnt == CNT_LAST);
  assign busy    = (state != IDLE) | ~empty;

  out_log_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (change),
    .wdata (outrisc_in),
    .pop   (pop),
    .rdata (rdata),
    .full  (fifo_full),
    .empty (empty)
  );

  // prev_q follows the input unconditionally so a dropped value is never retried.
  // NOTE: all state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      prev_q   <= '0;
      overflow <= 1'b0;
    end else begin
      prev_q <= outrisc_in;
      if (change && fifo_full && !pop) overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      uart_tx  <= LINE_IDLE;
      bit_cnt  <= '0;
      bit_idx  <= '0;
      byte_sel <= 1'b0;
      shift_q  <= '0;
      hi_q     <= '0;
`ifdef OUT_LOG_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      bit_cnt <= (state == IDLE || bit_end) ? '0 : bit_cnt + 1'b1;
      case (state)
        IDLE: begin
          if (!empty) begin
            shift_q  <= rdata[UART_DATA_BITS-1:0];
            hi_q     <= rdata[2*UART_DATA_BITS-1:UART_DATA_BITS];
            byte_sel <= 1'b0;
            state    <= START;
            uart_tx  <= LINE_START;
`ifdef OUT_LOG_PARITY_EN
            parity_q <= even_parity(rdata[UART_DATA_BITS-1:0]);
`endif
          end
        end
        START: begin
          if (bit_end) begin
            state   <= DATA;
            bit_idx <= '0;
            uart_tx <= shift_q[0];
            shift_q <= shift_q >> 1;
          end
        end
        DATA: begin
          if (bit_end) begin
            if (bit_idx == BIT_LAST) begin
`ifdef OUT_LOG_PARITY_EN
              state   <= PARITY;
              uart_tx <= parity_q;
`else
              state   <= STOP;
              uart_tx <= LINE_STOP;
`endif
            end else begin
              bit_idx <= bit_idx + 1'b1;
              uart_tx <= shift_q[0];
              shift_q <= shift_q >> 1;
            end
          end
        end
        PARITY: begin
          if (bit_end) begin
            state   <= STOP;
            uart_tx <= LINE_STOP;
          end
        end
        STOP: begin
          if (bit_end) begin
            if (!byte_sel) begin
              // High byte follows back-to-back with no idle gap.
              byte_sel <= 1'b1;
              shift_q  <= hi_q;
              state    <= START;
              uart_tx  <= LINE_START;
`ifdef OUT_LOG_PARITY_EN
              parity_q <= even_parity(hi_q);
`endif
            end else begin
              state   <= IDLE;
              uart_tx <= LINE_IDLE;
            end
          end
        end
        default: begin
          state   <= IDLE;
          uart_tx <= LINE_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_risc_out_uart_logger.sv
// Self-checking bench: per-cycle line/queue model plus hand-decoded frames.
module tb_risc_out_uart_logger;

  localparam int CBP   = 4;
  localparam int DEPTH = 8;
`ifdef OUT_LOG_PARITY_EN
  localparam int FB       = 11;
  localparam int WORD_CYC = 88;
`else
  localparam int FB       = 10;
  localparam int WORD_CYC = 80;
`endif
  localparam int FRAME_SMP = 2 * FB * CBP;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] outrisc_in = 16'h0000;
  logic        uart_tx;
  logic        busy;
  logic        fifo_full;
  logic        overflow;

  risc_out_uart_logger #(
    .DATA_W       (16),
    .FIFO_DEPTH   (DEPTH),
    .CLKS_PER_BIT (CBP)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .outrisc_in (outrisc_in),
    .uart_tx    (uart_tx),
    .busy       (busy),
    .fifo_full  (fifo_full),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: words waiting, and the per-cycle line levels of the frame in flight.
  logic [15:0] mq[$];
  bit          lq[$];
  bit          m_valid = 1'b0;
  bit          m_ending;
  bit          m_on;
  logic        m_tx, m_busy, m_full, m_ovf;
  logic [15:0] m_prev, m_word;
  logic [7:0]  m_byte;

  task automatic push_level(input bit b);
    for (int c = 0; c < CBP; c++) lq.push_back(b);
  endtask

  always @(posedge clk) begin
    if (reset) begin
      mq.delete();
      lq.delete();
      m_ending = 1'b0;
      m_on     = 1'b0;
      m_prev   = 16'h0000;
      m_ovf    = 1'b0;
      m_tx     = 1'b1;
      m_valid  = 1'b1;
    end else if (m_valid) begin
      if (lq.size() > 0) begin
        m_tx = lq.pop_front();
        m_on = 1'b1;
        if (lq.size() == 0) m_ending = 1'b1;
      end else if (m_ending) begin
        m_ending = 1'b0;
        m_tx     = 1'b1;
        m_on     = 1'b0;
      end else if (mq.size() > 0) begin
        m_word = mq.pop_front();
        for (int j = 0; j < 2; j++) begin
          m_byte = (j == 0) ? m_word[7:0] : m_word[15:8];
          push_level(1'b0);
          for (int k = 0; k < 8; k++) push_level(m_byte[k]);
`ifdef OUT_LOG_PARITY_EN
          push_level(^m_byte);
`endif
          push_level(1'b1);
        end
        m_tx = lq.pop_front();
        m_on = 1'b1;
      end else begin
        m_tx = 1'b1;
        m_on = 1'b0;
      end
      if (outrisc_in != m_prev) begin
        if (mq.size() < DEPTH) mq.push_back(outrisc_in);
        else m_ovf = 1'b1;
        m_prev = outrisc_in;
      end
    end
    m_busy = m_on || (mq.size() > 0);
    m_full = (mq.size() == DEPTH);
  end

  always @(negedge clk) begin
    if (m_valid)
      check("cycle {tx,busy,full,ovf}", {uart_tx, busy, fifo_full, overflow},
            {m_tx, m_busy, m_full, m_ovf});
  end

  int   falls = 0;
  logic last_tx = 1'b1;
  always @(negedge clk) begin
    if (last_tx === 1'b1 && uart_tx === 1'b0) falls++;
    last_tx = uart_tx;
  end

  logic smp [FRAME_SMP];
  int   bcnt;

  task automatic capture(input string tag);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (uart_tx !== 1'b0 && n < 200);
    check({tag, " start_seen"}, uart_tx === 1'b0, 1);
    bcnt = 0;
    for (int i = 0; i < FRAME_SMP; i++) begin
      if (i > 0) @(negedge clk);
      smp[i] = uart_tx;
      if (busy === 1'b1) bcnt++;
    end
    n = 0;
    while (busy === 1'b1 && n < 400) begin
      @(negedge clk);
      n++;
      if (busy === 1'b1) bcnt++;
    end
  endtask

  function automatic logic [7:0] rx_byte(input int j);
    logic [7:0] r;
    for (int k = 0; k < 8; k++) r[k] = smp[(j * FB + 1 + k) * CBP + 2];
    return r;
  endfunction

  task automatic check_frame(input string tag, input logic [7:0] lo, input logic [7:0] hi);
    check({tag, " start0"}, smp[2], 0);
    check({tag, " stop0"}, smp[(FB - 1) * CBP + 2], 1);
    check({tag, " start1"}, smp[FB * CBP + 2], 0);
    check({tag, " stop1"}, smp[(2 * FB - 1) * CBP + 2], 1);
    check({tag, " byte0"}, rx_byte(0), lo);
    check({tag, " byte1"}, rx_byte(1), hi);
    check({tag, " busy_cycles"}, bcnt, WORD_CYC);
  endtask

  task automatic drive(input logic [15:0] v);
    @(posedge clk);
    #1 outrisc_in = v;
  endtask

  logic [15:0] burst [10] = '{16'h0001, 16'h0002, 16'h0003, 16'h0004, 16'h0005,
                              16'h0006, 16'h0007, 16'h0008, 16'h0009, 16'h000A};

  initial begin
    int f0;
    int n;

    // 1: reset, no activity
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    repeat (20) @(negedge clk);
    check("t1 tx_idle", uart_tx, 1);
    check("t1 busy", busy, 0);
    check("t1 full", fifo_full, 0);
    check("t1 overflow", overflow, 0);
    check("t1 no_frame", falls, 0);

    // 2: single word, low byte first
    drive(16'h1234);
    capture("t2");
    check_frame("t2", 8'h34, 8'h12);
    check("t2 busy_after", busy, 0);

    // 3: constant input sends nothing more
    f0 = falls;
    repeat (100) @(negedge clk);
    check("t3 no_resend", falls - f0, 0);
    check("t3 busy", busy, 0);

    // 4: burst of ten into a depth-8 FIFO while transmitting
    for (int i = 0; i < 10; i++) drive(burst[i]);
    @(posedge clk);
    @(negedge clk);
    check("t4 full", fifo_full, 1);
    check("t4 overflow", overflow, 1);
    repeat (72) @(posedge clk);
    #1 outrisc_in = 16'h00BB;
    @(posedge clk);
    @(negedge clk);
    check("t4 push_pop_full", fifo_full, 1);
    n = 0;
    while (busy !== 1'b0 && n < 1500) begin
      @(negedge clk);
      n++;
    end
    check("t4 drained", busy, 0);
    check("t4 overflow_sticky", overflow, 1);
    check("t4 full_after", fifo_full, 0);

    // 5: reset in DATA bit 3 of 0xA5
    drive(16'hA5A5);
    repeat (18) @(posedge clk);
    #1;
    reset      = 1'b1;
    outrisc_in = 16'h0000;
    @(negedge clk);
    check("t5 data_bit3", uart_tx, 0);
    @(posedge clk);
    @(negedge clk);
    check("t5 tx_after_reset", uart_tx, 1);
    check("t5 busy_after_reset", busy, 0);
    #1 reset = 1'b0;
    f0 = falls;
    repeat (100) @(negedge clk);
    check("t5 no_resume", falls - f0, 0);
    check("t5 busy", busy, 0);

    // 6: word 0x0301 (parity 1 then 0 when enabled)
    drive(16'h0301);
    capture("t6");
    check_frame("t6", 8'h01, 8'h03);
`ifdef OUT_LOG_PARITY_EN
    check("t6 parity0", smp[9 * CBP + 2], 1);
    check("t6 parity1", smp[(FB + 9) * CBP + 2], 0);
`endif

    repeat (4) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1);
  end

endmodule
